// File: rtl/vector_mem_pkg.sv
// rtl/vector_mem_pkg.sv - shared types and constants for the vector data memory and its block copier
//
// Purpose: default geometry of the vector data memory, the packed vector type
//          used by memory, register file and copier, and the copier state enum.
// Ports:   none (package).
package vector_mem_pkg;

   localparam int DATA_SIZE       = 32;
   localparam int ADDRESSING_SIZE = 32;
   localparam int VEC_SIZE        = 4;
   localparam int MAX_COUNT       = 64;

   localparam int BYTES_PER_ELEM  = DATA_SIZE / 8;
   localparam int STEP            = VEC_SIZE * BYTES_PER_ELEM;

   typedef logic [VEC_SIZE-1:0][DATA_SIZE-1:0] vec_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } copier_state_t;

endpackage

// File: rtl/vector_block_copier.sv
// rtl/vector_block_copier.sv - block copy master for the vector data memory port
//
// Purpose: copies count consecutive vectors from src_addr to dst_addr with
//          alternating read/write cycles on the single memory port, choosing a
//          descending walk when the destination overlaps above the source.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, src_addr, dst_addr,
//   count                      copy request, sampled only when idle
//   abort                      stop request, honoured in READ/WRITE
//   busy, done, err            status: copying / completion pulse / reject pulse
//   mem_write_enable,
//   mem_DataAdr,
//   mem_toWrite_data           memory port outputs (zero when not copying)
//   mem_read_data              registered memory read data
module vector_block_copier
   import vector_mem_pkg::*;
#(
   parameter int dataSize       = DATA_SIZE,
   parameter int addressingSize = ADDRESSING_SIZE,
   parameter int vecSize        = VEC_SIZE,
   parameter int maxCount       = MAX_COUNT,
   parameter int countW         = $clog2(maxCount + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [addressingSize-1:0]   src_addr,
   input  logic [addressingSize-1:0]   dst_addr,
   input  logic [countW-1:0]           count,
   input  logic                        abort,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic                        mem_write_enable,
   output logic [addressingSize-1:0]   mem_DataAdr,
   output logic [vecSize*dataSize-1:0] mem_toWrite_data,
   input  logic [vecSize*dataSize-1:0] mem_read_data
);

   localparam int ELEM_BYTES = dataSize / 8;
   localparam int VEC_STEP   = vecSize * ELEM_BYTES;
   localparam int STEP_SH    = $clog2(VEC_STEP);
   localparam bit STEP_POW2  = (VEC_STEP == (1 << STEP_SH));
   localparam int AW1        = addressingSize + 1;
   localparam logic [addressingSize-1:0] ALIGN_MASK = addressingSize'(ELEM_BYTES - 1);

   copier_state_t             state, state_nxt;
   logic [addressingSize-1:0] src_q, dst_q;
   logic [countW-1:0]         cnt_q, index;
   logic                      desc_q;
   logic                      err_q;

   logic                      reject, accept, descending, last_vec;
   logic [AW1-1:0]            span_end;
   logic [addressingSize-1:0] idx_off;

   // Overlap detection on the incoming request. One extra bit keeps the end of
   // the source span from wrapping, so a span crossing the top of the address
   // space still compares as "above" the destination.
   always_comb begin
      span_end = '0;
      descending = 1'b0;
      if (STEP_POW2) begin
         span_end = {1'b0, src_addr} + (AW1'(count) << STEP_SH);
      end else begin
         span_end = {1'b0, src_addr} + AW1'(count) * AW1'(VEC_STEP);
      end
      descending = (dst_addr > src_addr) && ({1'b0, dst_addr} < span_end);
   end

   assign reject = (count == '0)
                || (count > countW'(maxCount))
                || ((src_addr & ALIGN_MASK) != '0)
                || ((dst_addr & ALIGN_MASK) != '0);

   assign accept   = (state == IDLE) && start && !reject;
   assign last_vec = desc_q ? (index == '0) : (index == cnt_q - countW'(1));

   // Byte offset of the current vector; constant-folded to a shift at default sizes.
   assign idx_off = STEP_POW2 ? (addressingSize'(index) << STEP_SH)
                              : (addressingSize'(index) * addressingSize'(VEC_STEP));

   assign err = err_q;

   always_comb begin
      state_nxt        = state;
      busy             = 1'b0;
      done             = 1'b0;
      mem_write_enable = 1'b0;
      mem_DataAdr      = '0;
      mem_toWrite_data = '0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = READ;
         end
         READ: begin
            busy        = 1'b1;
            mem_DataAdr = src_q + idx_off;
            state_nxt   = abort ? DONE : WRITE;
         end
         WRITE: begin
            busy             = 1'b1;
            mem_write_enable = 1'b1;
            mem_DataAdr      = dst_q + idx_off;
            // Memory read data arrives one cycle after the READ address.
            mem_toWrite_data = mem_read_data;
            state_nxt        = (abort || last_vec) ? DONE : READ;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         src_q  <= '0;
         dst_q  <= '0;
         cnt_q  <= '0;
         index  <= '0;
         desc_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         err_q <= (state == IDLE) && start && reject;
         if (accept) begin
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            cnt_q  <= count;
            desc_q <= descending;
            index  <= descending ? count - countW'(1) : '0;
         end else if ((state == WRITE) && !abort && !last_vec) begin
            index <= desc_q ? index - countW'(1) : index + countW'(1);
         end
      end
   end

endmodule

// File: tb/tb_vector_block_copier.sv
// tb/tb_vector_block_copier.sv - randomized self-checking bench for vector_block_copier
module tb_vector_block_copier;

   typedef struct {
      bit           busy;
      bit           done;
      bit           err;
      bit           we;
      logic [31:0]  addr;
      logic [127:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [31:0]  src_addr = '0;
   logic [31:0]  dst_addr = '0;
   logic [6:0]   count = '0;
   logic         busy, done, err, mem_we;
   logic [31:0]  mem_adr;
   logic [127:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   vector_block_copier dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .src_addr         (src_addr),
      .dst_addr         (dst_addr),
      .count            (count),
      .abort            (abort),
      .busy             (busy),
      .done             (done),
      .err              (err),
      .mem_write_enable (mem_we),
      .mem_DataAdr      (mem_adr),
      .mem_toWrite_data (mem_wdata),
      .mem_read_data    (mem_rdata)
   );

   int checks = 0;
   int failures = 0;
   exp_t exp_q[$];
   int pos, done_pos, busy_cnt, we_cnt;
   logic [31:0] first_addr;

   logic [31:0]  mem_arr [0:1023];
   logic [31:0]  shadow  [0:1023];
   logic [31:0]  snap    [0:1023];
   logic [127:0] rd_q = '0;
   bit load_en = 1'b0;
   bit load_rand = 1'b0;

   function automatic int eix(input logic [31:0] a, input int k);
      return int'(((a >> 2) + 32'(k)) & 32'h3FF);
   endfunction

   function automatic logic [127:0] mem_vec(input logic [31:0] a);
      logic [127:0] v;
      for (int k = 0; k < 4; k++) v[32*k +: 32] = mem_arr[eix(a, k)];
      return v;
   endfunction

   function automatic logic [127:0] snap_vec(input logic [31:0] a);
      logic [127:0] v;
      for (int k = 0; k < 4; k++) v[32*k +: 32] = snap[eix(a, k)];
      return v;
   endfunction

   // Single-port memory: registered read, read data held across writes.
   always @(posedge clk) begin
      if (load_en) begin
         for (int e = 0; e < 1024; e++) mem_arr[e] <= load_rand ? $urandom : 32'(32'h100 + e);
      end else if (mem_we) begin
         for (int k = 0; k < 4; k++) mem_arr[eix(mem_adr, k)] <= mem_wdata[32*k +: 32];
      end else begin
         rd_q <= mem_vec(mem_adr);
      end
   end
   assign mem_rdata = rd_q;

   task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
      end
   endtask

   // Compare process: one expected entry per cycle while a copy is in flight,
   // otherwise the port must be quiet.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pos++;
            check("busy", busy, e.busy);
            check("done", done, e.done);
            check("err", err, e.err);
            check("we", mem_we, e.we);
            check("wdata", mem_wdata, e.data);
            if (e.busy) check("addr", mem_adr, e.addr);
            if (pos == 1) first_addr = mem_adr;
            if (done) done_pos = pos;
            if (busy) busy_cnt++;
            if (mem_we) we_cnt++;
         end else if (rst_n) begin
            check("idle_quiet", {busy, done, err, mem_we}, 4'b0);
            check("idle_wdata", mem_wdata, 128'd0);
         end
      end
   end

   task automatic drain_and_check_mem();
      int mism;
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
      check("drain", exp_q.size(), 0);
      @(negedge clk);
      mism = 0;
      for (int x = 0; x < 1024; x++) if (mem_arr[x] !== shadow[x]) mism++;
      check("mem_image", mism, 0);
   endtask

   task automatic do_load(input bit rnd);
      @(negedge clk);
      load_rand = rnd;
      load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
      for (int x = 0; x < 1024; x++) shadow[x] = mem_arr[x];
   endtask

   // Model: memmove of n vectors, walked high-to-low when dst overlaps above src.
   // abort_at > 0 truncates the traffic after that cycle.
   task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                           input int abort_at, input bit poke);
      exp_t e;
      int last_c, i;
      bit desc;
      for (int x = 0; x < 1024; x++) snap[x] = shadow[x];
      desc = (d > s) && ({1'b0, d} < ({1'b0, s} + 33'(n * 16)));
      last_c = (abort_at > 0) ? abort_at : 2 * n;
      @(negedge clk);
      src_addr = s;
      dst_addr = d;
      count = 7'(n);
      start = 1'b1;
      pos = 0; done_pos = -1; busy_cnt = 0; we_cnt = 0;
      for (int c = 1; c <= last_c; c++) begin
         i = desc ? (n - 1 - (c - 1) / 2) : ((c - 1) / 2);
         e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0;
         if (c % 2 == 1) begin
            e.we = 1'b0; e.addr = s + 32'(i * 16); e.data = '0;
         end else begin
            e.we = 1'b1; e.addr = d + 32'(i * 16); e.data = snap_vec(s + 32'(i * 16));
            for (int k = 0; k < 4; k++) shadow[eix(e.addr, k)] = e.data[32*k +: 32];
         end
         exp_q.push_back(e);
      end
      e.busy = 1'b0; e.done = 1'b1; e.err = 1'b0; e.we = 1'b0; e.addr = '0; e.data = '0;
      exp_q.push_back(e);
      for (int c = 1; c <= last_c + 1; c++) begin
         @(negedge clk);
         start = poke && (c == 3) && (c <= last_c);
         if (start) begin
            src_addr = 32'($urandom) & 32'h0000_0FFE;
            dst_addr = 32'($urandom) & 32'h0000_0FFC;
            count = 7'($urandom_range(1, 64));
         end
         abort = (c == abort_at);
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      drain_and_check_mem();
   endtask

   task automatic run_reject(input logic [31:0] s, input logic [31:0] d, input int n);
      exp_t e;
      @(negedge clk);
      src_addr = s; dst_addr = d; count = 7'(n); start = 1'b1;
      pos = 0;
      e.busy = 1'b0; e.done = 1'b0; e.err = 1'b1; e.we = 1'b0; e.addr = '0; e.data = '0;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      drain_and_check_mem();
   endtask

   initial begin
      exp_t e;
      int n, mode, lim;
      logic [31:0] s, d;

      #1;
      check("reset_outputs", {busy, done, err, mem_we, (mem_adr != 0), (mem_wdata != 0)}, 6'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      do_load(1'b0);

      // Basic ascending copy: elements hold 0x100+i.
      run_copy(32'h000, 32'h100, 3, 0, 1'b0);
      check("basic_done_cycle", done_pos, 7);
      check("basic_busy_cycles", busy_cnt, 6);
      check("basic_v0e0", mem_arr[32'h100 >> 2], 32'h100);
      check("basic_v2e3", mem_arr[(32'h120 >> 2) + 3], 32'h10B);

      // Overlap with destination above source: walked descending.
      run_copy(32'h040, 32'h050, 4, 0, 1'b0);
      check("desc_first_read", first_addr, 32'h070);
      check("desc_dst0", mem_arr[32'h050 >> 2], 32'h110);
      check("desc_dst3", mem_arr[32'h080 >> 2], 32'h11C);

      // Rejected requests.
      run_reject(32'h000, 32'h100, 0);
      run_reject(32'h000, 32'h100, 65);
      run_reject(32'h002, 32'h100, 4);
      run_reject(32'h000, 32'h101, 4);

      // Abort during READ of vector 2.
      run_copy(32'h200, 32'h400, 8, 5, 1'b0);
      check("abort_writes", we_cnt, 2);
      check("abort_done_cycle", done_pos, 6);
      check("abort_v1_written", mem_arr[32'h410 >> 2], 32'h184);
      check("abort_v2_untouched", mem_arr[32'h420 >> 2], 32'h208);

      // New start accepted afterwards, with a start pulse poked mid-copy.
      run_copy(32'h300, 32'h380, 3, 0, 1'b1);
      check("after_abort_writes", we_cnt, 3);

      // Asynchronous reset during the WRITE of vector 0.
      for (int x = 0; x < 1024; x++) snap[x] = shadow[x];
      @(negedge clk);
      src_addr = 32'h200; dst_addr = 32'h600; count = 7'd5; start = 1'b1;
      pos = 0;
      e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0; e.we = 1'b0; e.addr = 32'h200; e.data = '0;
      exp_q.push_back(e);
      e.we = 1'b1; e.addr = 32'h600; e.data = snap_vec(32'h200);
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_mid_we", mem_we, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_done", done, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      drain_and_check_mem();
      run_copy(32'h200, 32'h600, 5, 0, 1'b0);
      check("post_reset_done_cycle", done_pos, 11);

      // Randomized copies on random memory contents.
      do_load(1'b1);
      for (int t = 0; t < 16; t++) begin
         n = $urandom_range(1, 40);
         lim = 32'h1000 - n * 16 - 32'h40;
         s = 32'($urandom_range(32'h40, lim)) & 32'hFFFF_FFFC;
         mode = $urandom_range(0, 3);
         case (mode)
            0: d = 32'($urandom_range(32'h40, lim)) & 32'hFFFF_FFFC;
            1: d = s + 32'(4 * $urandom_range(1, 12));
            2: d = s - 32'(4 * $urandom_range(1, 12));
            default: d = s;
         endcase
         run_copy(s, d, n, ($urandom_range(0, 9) < 3) ? $urandom_range(1, 2 * n) : 0,
                  1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
